idx_dec: RTL and testbench

Registered binary-index-to-one-hot decoder with an accumulating occupancy bit vector, the inverse companion of the priority encoder. It accepts `{index, set/clear}` commands over a valid/ready handshake and emits the decoded one-hot word plus an error flag one cycle later. It also maintains a live bit vector and population count of the indices currently set. It sits on the release/allocate side of free-list and tag-tracking structures, where the priority encoder picks an entry and this block marks it busy or free.

---
 rtl/idx_dec.sv | 92 +++++++++
 tb/tb_idx_dec.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/idx_dec.sv
// idx_dec: registered binary-index to one-hot decoder with an occupancy
// vector and population count, driven over a valid/ready handshake.
module idx_dec #(
   parameter int    OUT = 32,
   parameter string ACT = "High",
   parameter int    IN  = $clog2(OUT)
) (
   input  logic           clk,
   input  logic           reset,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [IN-1:0]  in_idx,
   input  logic           in_set,
   input  logic           flush,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [OUT-1:0] out_vec,
   output logic           out_err,
   output logic [OUT-1:0] vec,
   output logic [IN:0]    cnt,
   output logic           full,
   output logic           empty
);

   localparam bit LOW = (ACT == "Low");

   logic           r_out_valid;
   logic           r_out_err;
   logic [OUT-1:0] r_out_vec;
   logic [OUT-1:0] r_occ;
   logic [IN:0]    r_cnt;

   logic           w_accept;
   logic           w_in_range;
   logic [OUT-1:0] w_onehot;
   logic           w_cur;
   logic           w_redund;
   logic           w_err;
   logic           w_eff;

   assign in_ready   = !flush && (!r_out_valid || out_ready);
   assign w_accept   = in_valid && in_ready;
   assign w_in_range = 32'(in_idx) < 32'(OUT);
   assign w_onehot   = w_in_range ? (OUT'(1) << in_idx) : '0;
   assign w_cur      = |(r_occ & w_onehot);
   assign w_redund   = in_set ? w_cur : !w_cur;
   assign w_err      = !w_in_range || w_redund;
   assign w_eff      = w_accept && w_in_range && !w_redund;

   // State is kept active-high internally; ACT only flips the exported vectors.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_out_err   <= 1'b0;
         r_out_vec   <= '0;
         r_occ       <= '0;
         r_cnt       <= '0;
      end else if (flush) begin
         r_out_valid <= 1'b0;
         r_out_err   <= 1'b0;
         r_out_vec   <= '0;
         r_occ       <= '0;
         r_cnt       <= '0;
      end else begin
         if (w_accept) begin
            r_out_valid <= 1'b1;
            r_out_err   <= w_err;
            r_out_vec   <= w_onehot;
         end else if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
         end
         if (w_eff) begin
            if (in_set) begin
               r_occ <= r_occ | w_onehot;
               r_cnt <= r_cnt + (IN+1)'(1);
            end else begin
               r_occ <= r_occ & ~w_onehot;
               r_cnt <= r_cnt - (IN+1)'(1);
            end
         end
      end
   end

   assign out_valid = r_out_valid;
   assign out_err   = r_out_err;
   assign out_vec   = LOW ? ~r_out_vec : r_out_vec;
   assign vec       = LOW ? ~r_occ : r_occ;
   assign cnt       = r_cnt;
   assign full      = (r_cnt == (IN+1)'(OUT));
   assign empty     = (r_cnt == '0);

endmodule

// File: tb/tb_idx_dec.sv
// Directed bench for idx_dec: OUT=32/High instance (a_*) and OUT=20/Low instance (b_*).
module tb_idx_dec;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        a_in_valid, a_in_ready, a_in_set, a_flush, a_out_valid, a_out_ready, a_out_err, a_full, a_empty;
   logic [4:0]  a_in_idx;
   logic [31:0] a_out_vec, a_vec;
   logic [5:0]  a_cnt;

   logic        b_in_valid, b_in_ready, b_in_set, b_flush, b_out_valid, b_out_ready, b_out_err, b_full, b_empty;
   logic [4:0]  b_in_idx;
   logic [19:0] b_out_vec, b_vec;
   logic [5:0]  b_cnt;

   int checks = 0;
   int errors = 0;

   idx_dec #(.OUT(32), .ACT("High")) u_a (
      .clk(clk), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_idx(a_in_idx), .in_set(a_in_set), .flush(a_flush), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_vec(a_out_vec), .out_err(a_out_err), .vec(a_vec),
      .cnt(a_cnt), .full(a_full), .empty(a_empty)
   );

   idx_dec #(.OUT(20), .ACT("Low")) u_b (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_idx(b_in_idx), .in_set(b_in_set), .flush(b_flush), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_vec(b_out_vec), .out_err(b_out_err), .vec(b_vec),
      .cnt(b_cnt), .full(b_full), .empty(b_empty)
   );

   task automatic cmd_a(input logic [4:0] idx, input logic set);
      a_in_idx = idx; a_in_set = set; a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_valid = 1'b0;
   endtask

   task automatic cmd_b(input logic [4:0] idx, input logic set);
      b_in_idx = idx; b_in_set = set; b_in_valid = 1'b1;
      @(posedge clk); #1;
      b_in_valid = 1'b0;
   endtask

   task automatic test_reset;
      reset = 1'b1;
      a_in_valid = 0; a_in_idx = 0; a_in_set = 0; a_flush = 0; a_out_ready = 1;
      b_in_valid = 0; b_in_idx = 0; b_in_set = 0; b_flush = 0; b_out_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got %b exp 0", a_out_valid); end
      checks++; if (a_out_err !== 1'b0) begin errors++; $display("FAIL rst_out_err got %b exp 0", a_out_err); end
      checks++; if (a_out_vec !== 32'h0) begin errors++; $display("FAIL rst_out_vec got %h exp 0", a_out_vec); end
      checks++; if (a_vec !== 32'h0) begin errors++; $display("FAIL rst_vec got %h exp 0", a_vec); end
      checks++; if (a_cnt !== 6'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", a_cnt); end
      checks++; if (a_empty !== 1'b1 || a_full !== 1'b0) begin errors++; $display("FAIL rst_empty_full got %b%b exp 10", a_empty, a_full); end
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL rst_in_ready got %b exp 1", a_in_ready); end
      checks++; if (b_vec !== 20'hFFFFF || b_out_vec !== 20'hFFFFF) begin errors++; $display("FAIL rst_low_vec got %h/%h exp fffff", b_vec, b_out_vec); end
      reset = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_set;
      cmd_a(5'd5, 1'b1);
      checks++; if (a_out_valid !== 1'b1) begin errors++; $display("FAIL set_out_valid got %b exp 1", a_out_valid); end
      checks++; if (a_out_vec !== 32'h20) begin errors++; $display("FAIL set_out_vec got %h exp 20", a_out_vec); end
      checks++; if (a_out_err !== 1'b0) begin errors++; $display("FAIL set_out_err got %b exp 0", a_out_err); end
      checks++; if (a_vec !== 32'h20) begin errors++; $display("FAIL set_vec got %h exp 20", a_vec); end
      checks++; if (a_cnt !== 6'd1 || a_empty !== 1'b0) begin errors++; $display("FAIL set_cnt got %0d/%b exp 1/0", a_cnt, a_empty); end
   endtask

   task automatic test_redundant;
      cmd_a(5'd5, 1'b1);
      checks++; if (a_out_err !== 1'b1) begin errors++; $display("FAIL redset_err got %b exp 1", a_out_err); end
      checks++; if (a_out_vec !== 32'h20) begin errors++; $display("FAIL redset_out_vec got %h exp 20", a_out_vec); end
      checks++; if (a_vec !== 32'h20 || a_cnt !== 6'd1) begin errors++; $display("FAIL redset_state got %h/%0d exp 20/1", a_vec, a_cnt); end
   endtask

   task automatic test_clear;
      cmd_a(5'd5, 1'b0);
      checks++; if (a_vec !== 32'h0 || a_cnt !== 6'd0) begin errors++; $display("FAIL clr_state got %h/%0d exp 0/0", a_vec, a_cnt); end
      checks++; if (a_empty !== 1'b1 || a_out_err !== 1'b0) begin errors++; $display("FAIL clr_empty_err got %b/%b exp 1/0", a_empty, a_out_err); end
      cmd_a(5'd5, 1'b0);
      checks++; if (a_out_err !== 1'b1) begin errors++; $display("FAIL redclr_err got %b exp 1", a_out_err); end
      checks++; if (a_out_vec !== 32'h20 || a_cnt !== 6'd0) begin errors++; $display("FAIL redclr_vec got %h/%0d exp 20/0", a_out_vec, a_cnt); end
   endtask

   task automatic test_back_to_back;
      @(posedge clk); #1;
      checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL retire_valid got %b exp 0", a_out_valid); end
      a_out_ready = 1'b0;
      cmd_a(5'd7, 1'b1);
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready got %b exp 0", a_in_ready); end
      a_in_idx = 5'd9; a_in_set = 1'b1; a_in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         checks++; if (a_out_vec !== 32'h80 || a_out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold%0d got %h/%b exp 80/1", i, a_out_vec, a_out_valid); end
         checks++; if (a_vec !== 32'h80) begin errors++; $display("FAIL bp_vec%0d got %h exp 80", i, a_vec); end
      end
      a_out_ready = 1'b1;
      #1;
      checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %b exp 1", a_in_ready); end
      @(posedge clk); #1;
      a_in_valid = 1'b0;
      checks++; if (a_out_vec !== 32'h200 || a_out_valid !== 1'b1) begin errors++; $display("FAIL b2b_out got %h/%b exp 200/1", a_out_vec, a_out_valid); end
      checks++; if (a_vec !== 32'h280 || a_cnt !== 6'd2) begin errors++; $display("FAIL b2b_state got %h/%0d exp 280/2", a_vec, a_cnt); end
   endtask

   task automatic test_act_low;
      cmd_b(5'd3, 1'b1);
      checks++; if (b_vec !== 20'hFFFF7) begin errors++; $display("FAIL low_vec got %h exp ffff7", b_vec); end
      checks++; if (b_out_vec !== 20'hFFFF7 || b_out_err !== 1'b0) begin errors++; $display("FAIL low_out got %h/%b exp ffff7/0", b_out_vec, b_out_err); end
      cmd_b(5'd25, 1'b1);
      checks++; if (b_out_vec !== 20'hFFFFF || b_out_err !== 1'b1) begin errors++; $display("FAIL low_oor got %h/%b exp fffff/1", b_out_vec, b_out_err); end
      checks++; if (b_cnt !== 6'd1 || b_vec !== 20'hFFFF7) begin errors++; $display("FAIL low_oor_state got %0d/%h exp 1/ffff7", b_cnt, b_vec); end
      cmd_b(5'd19, 1'b1);
      checks++; if (b_out_vec !== 20'h7FFFF || b_out_err !== 1'b0 || b_cnt !== 6'd2) begin errors++; $display("FAIL low_top got %h/%b/%0d exp 7ffff/0/2", b_out_vec, b_out_err, b_cnt); end
      cmd_b(5'd20, 1'b0);
      checks++; if (b_out_err !== 1'b1 || b_vec !== 20'h7FFF7) begin errors++; $display("FAIL low_edge got %b/%h exp 1/7fff7", b_out_err, b_vec); end
   endtask

   task automatic test_full_flush;
      logic [31:0] exp_oh;
      a_flush = 1'b1;
      @(posedge clk); #1;
      a_flush = 1'b0;
      a_in_valid = 1'b1; a_in_set = 1'b1;
      for (int i = 0; i < 32; i++) begin
         a_in_idx = 5'(i);
         @(posedge clk); #1;
         exp_oh = 32'h1 << i;
         checks++; if (a_out_vec !== exp_oh || a_out_err !== 1'b0) begin errors++; $display("FAIL fill%0d got %h/%b exp %h/0", i, a_out_vec, a_out_err, exp_oh); end
      end
      a_in_valid = 1'b0;
      checks++; if (a_cnt !== 6'd32 || a_full !== 1'b1) begin errors++; $display("FAIL full got %0d/%b exp 32/1", a_cnt, a_full); end
      checks++; if (a_vec !== 32'hFFFFFFFF) begin errors++; $display("FAIL full_vec got %h exp ffffffff", a_vec); end
      cmd_a(5'd0, 1'b0);
      checks++; if (a_cnt !== 6'd31 || a_full !== 1'b0) begin errors++; $display("FAIL unfull got %0d/%b exp 31/0", a_cnt, a_full); end
      a_flush = 1'b1; a_in_valid = 1'b1; a_in_idx = 5'd0; a_in_set = 1'b1;
      #1;
      checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", a_in_ready); end
      @(posedge clk); #1;
      a_flush = 1'b0; a_in_valid = 1'b0;
      checks++; if (a_vec !== 32'h0 || a_cnt !== 6'd0) begin errors++; $display("FAIL flush_state got %h/%0d exp 0/0", a_vec, a_cnt); end
      checks++; if (a_out_valid !== 1'b0 || a_out_vec !== 32'h0 || a_out_err !== 1'b0) begin errors++; $display("FAIL flush_out got %b/%h/%b exp 0/0/0", a_out_valid, a_out_vec, a_out_err); end
   endtask

   task automatic test_reset_mid;
      a_in_idx = 5'd10; a_in_set = 1'b1; a_in_valid = 1'b1;
      @(posedge clk); #1;
      a_in_idx = 5'd11;
      checks++; if (a_vec !== 32'h400) begin errors++; $display("FAIL pre_rst_vec got %h exp 400", a_vec); end
      #2 reset = 1'b1;
      #1;
      checks++; if (a_out_valid !== 1'b0 || a_out_vec !== 32'h0 || a_out_err !== 1'b0) begin errors++; $display("FAIL arst_out got %b/%h/%b exp 0/0/0", a_out_valid, a_out_vec, a_out_err); end
      checks++; if (a_vec !== 32'h0 || a_cnt !== 6'd0 || a_empty !== 1'b1) begin errors++; $display("FAIL arst_state got %h/%0d/%b exp 0/0/1", a_vec, a_cnt, a_empty); end
      checks++; if (b_vec !== 20'hFFFFF || b_cnt !== 6'd0) begin errors++; $display("FAIL arst_low got %h/%0d exp fffff/0", b_vec, b_cnt); end
      a_in_valid = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;
      checks++; if (a_vec !== 32'h0 || a_out_valid !== 1'b0) begin errors++; $display("FAIL post_rst got %h/%b exp 0/0", a_vec, a_out_valid); end
   endtask

   initial begin
      test_reset();
      test_set();
      test_redundant();
      test_clear();
      test_back_to_back();
      test_act_low();
      test_full_flush();
      test_reset_mid();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running exp finished");
      $fatal(1);
   end

endmodule
